// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON block packer slice.
package ascon_pkg;

   localparam int unsigned BLOCK_BYTES = 8;
   localparam logic [3:0]  FULL_LEN    = 4'd8;

   typedef struct packed {
      logic [63:0] data;
      logic [3:0]  len;
   } ascon_blk_t;

   typedef enum logic {
      FILL,
      PAD0
   } pack_state_t;

endpackage

// File: rtl/ascon_block_packer_if.sv
// Byte stream in, block stream out, between the feeder and the ASCON controller.
interface ascon_block_packer_if;

   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_null;
   logic        s_ready;
   logic        blk_take;
   logic [63:0] blk_data;
   logic [3:0]  blk_len;
   logic        blk_valid;

   modport master (
      output s_data, s_valid, s_last, s_null, blk_take,
      input  s_ready, blk_data, blk_len, blk_valid
   );

   modport slave (
      input  s_data, s_valid, s_last, s_null, blk_take,
      output s_ready, blk_data, blk_len, blk_valid
   );

endinterface

// File: rtl/ascon_blk_fifo.sv
// Small synchronous FIFO of rate blocks; head entry reads zero when empty.
module ascon_blk_fifo
   import ascon_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    nRST,
   input  logic                    i_clr,
   input  logic                    i_push,
   input  ascon_blk_t              i_din,
   input  logic                    i_pop,
   output ascon_blk_t              o_dout,
   output logic                    o_full,
   output logic                    o_empty,
   output logic [$clog2(DEPTH):0]  o_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   ascon_blk_t       r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;

   assign o_full  = (r_level == LW'(DEPTH));
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

   // Storage, pointers and occupancy; clear has priority over push/pop.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({i_push, i_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // The caller gates pops with non-empty and pushes with non-full.
   a_no_pop_empty: assert property (@(posedge clk) disable iff (!nRST) !(i_pop && o_empty && !i_clr));
   a_no_push_full: assert property (@(posedge clk) disable iff (!nRST) !(i_push && o_full && !i_clr));

endmodule

// File: rtl/ascon_block_packer.sv
// Packs a byte stream into 64-bit ASCON rate blocks with byte counts, queued for the controller.
module ascon_block_packer
   import ascon_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    nRST,
   input  logic                    clr,
   ascon_block_packer_if.slave     bus,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic                    underflow
);

   localparam logic [2:0] LAST_IDX = 3'(BLOCK_BYTES - 1);

   pack_state_t r_state;
   pack_state_t w_state_nxt;
   logic [63:0] r_acc;
   logic [63:0] w_acc_nxt;
   logic [63:0] w_ins;
   logic [2:0]  r_cnt;
   logic [2:0]  w_cnt_nxt;
   logic        w_accept;
   logic        w_push;
   logic        w_pop;
   logic        w_full;
   logic        w_empty;
   logic        r_underflow;
   ascon_blk_t  w_push_blk;
   ascon_blk_t  w_head;

   // Registered terms only, so blk_take never reaches s_ready combinationally.
   assign bus.s_ready   = (r_state == FILL) && !w_full;
   assign w_accept      = bus.s_valid && bus.s_ready;
   assign w_pop         = bus.blk_take && !w_empty;
   assign w_ins         = r_acc | ({56'b0, bus.s_data} << {3'd7 - r_cnt, 3'b000});

   assign bus.blk_data  = w_head.data;
   assign bus.blk_len   = w_head.len;
   assign bus.blk_valid = !w_empty;
   assign underflow     = r_underflow;

   // Next-state, accumulator update and block push decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_push      = 1'b0;
      w_push_blk  = '0;
      case (r_state)
         FILL: begin
            if (w_accept) begin
               if (bus.s_null) begin
                  w_push          = 1'b1;
                  w_push_blk.data = r_acc;
                  w_push_blk.len  = {1'b0, r_cnt};
                  w_acc_nxt       = '0;
                  w_cnt_nxt       = '0;
               end else if (bus.s_last || (r_cnt == LAST_IDX)) begin
                  w_push          = 1'b1;
                  w_push_blk.data = w_ins;
                  w_push_blk.len  = (r_cnt == LAST_IDX) ? FULL_LEN : ({1'b0, r_cnt} + 4'd1);
                  w_acc_nxt       = '0;
                  w_cnt_nxt       = '0;
                  // A segment ending exactly on a block boundary still needs its len-0 block.
                  if (bus.s_last && (r_cnt == LAST_IDX)) begin
                     w_state_nxt = PAD0;
                  end
               end else begin
                  w_acc_nxt = w_ins;
                  w_cnt_nxt = r_cnt + 3'd1;
               end
            end
         end
         PAD0: begin
            if (!w_full) begin
               w_push      = 1'b1;
               w_state_nxt = FILL;
            end
         end
         default: w_state_nxt = FILL;
      endcase
   end

   // Packer state register; clr flushes any partial block.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         r_state <= FILL;
         r_acc   <= '0;
         r_cnt   <= '0;
      end else if (clr) begin
         r_state <= FILL;
         r_acc   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Sticky flag for a take issued against an empty queue.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         r_underflow <= 1'b0;
      end else if (clr) begin
         r_underflow <= 1'b0;
      end else if (bus.blk_take && w_empty) begin
         r_underflow <= 1'b1;
      end
   end

   ascon_blk_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .nRST    (nRST),
      .i_clr   (clr),
      .i_push  (w_push),
      .i_din   (w_push_blk),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (fifo_level)
   );

endmodule
